wide_add_sequencer: RTL and testbench

Two-requester, multi-cycle wide adder controller. It arbitrates between two operand sources and computes each WIDTH-bit addition over WIDTH/SLICE cycles. Each cycle reuses one SLICE-bit ripple-carry adder instance (`ripple_carry_adder`, nbit=SLICE), and the carry is held in a register between slices. The block sits between operand producers in the npc datapath and any consumer that can tolerate multi-cycle latency, and trades throughput for adder area.

---
 rtl/wide_add_sequencer.sv | 109 ++++++++++
 tb/tb_wide_add_sequencer.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/wide_add_sequencer.sv
// wide_add_sequencer: two-port arbitrated WIDTH-bit adder that reuses one SLICE-bit
// ripple-carry slice over WIDTH/SLICE cycles, holding the inter-slice carry in a register.
module ripple_carry_adder #(
    parameter int nbit = 8
) (
    input  logic [nbit-1:0] i_a,
    input  logic [nbit-1:0] i_b,
    input  logic            i_cin,
    output logic [nbit-1:0] o_sum,
    output logic            o_cout
);
    logic [nbit:0] w_c;
    assign w_c[0] = i_cin;
    for (genvar i = 0; i < nbit; i++) begin : g_fa
        assign o_sum[i]  = i_a[i] ^ i_b[i] ^ w_c[i];
        assign w_c[i+1]  = (i_a[i] & i_b[i]) | (w_c[i] & (i_a[i] ^ i_b[i]));
    end
    assign o_cout = w_c[nbit];
endmodule

module wide_add_sequencer #(
    parameter int WIDTH = 32,
    parameter int SLICE = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [WIDTH-1:0] req_a0,
    input  logic [WIDTH-1:0] req_b0,
    input  logic [WIDTH-1:0] req_a1,
    input  logic [WIDTH-1:0] req_b1,
    input  logic [1:0]       req_cin,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [WIDTH-1:0] resp_sum,
    output logic             resp_cout,
    output logic             resp_id,
    output logic             busy
);
    localparam int N  = WIDTH / SLICE;
    localparam int CW = N > 1 ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           r_state, w_next;
    logic [WIDTH-1:0] r_a, r_b, r_sum;
    logic             r_carry, r_id, r_prio;
    logic [CW-1:0]    r_cnt;
    logic             w_gnt, w_acc, w_last, w_scout;
    logic [31:0]      w_base;
    logic [SLICE-1:0] w_ssum;

    // Under contention the prio port wins; otherwise whichever port is valid.
    assign w_gnt     = &req_valid ? r_prio : req_valid[1];
    assign w_acc     = r_state == IDLE && |req_valid;
    assign w_last    = r_cnt == CW'(N - 1);
    assign w_base    = 32'(r_cnt) * 32'(SLICE);
    assign req_ready = {2{w_acc & ~rst}} & (w_gnt ? 2'b10 : 2'b01);

    ripple_carry_adder #(.nbit(SLICE)) u_slice (
        .i_a   (r_a[w_base +: SLICE]),
        .i_b   (r_b[w_base +: SLICE]),
        .i_cin (r_carry),
        .o_sum (w_ssum),
        .o_cout(w_scout)
    );

    always_comb begin
        w_next = r_state;
        w_next = r_state == IDLE ? (|req_valid ? RUN : IDLE)
               : r_state == RUN  ? (w_last ? DONE : RUN)
               : (resp_ready ? IDLE : DONE);
    end

    // cnt returns to 0 on the last slice so the slice select never leaves the operand.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_id    <= 1'b0;
            r_prio  <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_acc) begin
                r_a     <= w_gnt ? req_a1 : req_a0;
                r_b     <= w_gnt ? req_b1 : req_b0;
                r_carry <= req_cin[w_gnt];
                r_cnt   <= '0;
                r_id    <= w_gnt;
                r_prio  <= ~w_gnt;
            end else if (r_state == RUN) begin
                r_sum[w_base +: SLICE] <= w_ssum;
                r_carry                <= w_scout;
                r_cnt                  <= w_last ? '0 : r_cnt + 1'b1;
            end
        end
    end

    assign resp_valid = r_state == DONE;
    assign busy       = r_state != IDLE;
    assign resp_sum   = r_sum;
    assign resp_cout  = r_carry;
    assign resp_id    = r_id;
endmodule

// File: tb/tb_wide_add_sequencer.sv
// tb_wide_add_sequencer: randomized check of three slice configurations against a+b+cin arithmetic.
module tb_wide_add_sequencer;
    logic        clk = 1'b0;
    logic        rst;
    logic        rr;
    logic [1:0]  v8, v32, v4, cin;
    logic [31:0] a0, b0, a1, b1;
    logic [1:0]  rdy8, rdy32, rdy4, m_ready;
    logic        rv8, rv32, rv4, m_rvalid;
    logic [31:0] s8, s32, s4, m_sum;
    logic        c8, c32, c4, m_cout;
    logic        id8, id32, id4, m_id;
    logic        bz8, bz32, bz4, m_busy;
    int          cur;
    int          nvec = 0;
    int          nerr = 0;
    logic [33:0] q[$];

    always #5 clk = ~clk;

    wide_add_sequencer #(.WIDTH(32), .SLICE(8)) u_d8 (
        .clk(clk), .rst(rst), .req_valid(v8), .req_ready(rdy8),
        .req_a0(a0), .req_b0(b0), .req_a1(a1), .req_b1(b1), .req_cin(cin),
        .resp_valid(rv8), .resp_ready(rr), .resp_sum(s8), .resp_cout(c8),
        .resp_id(id8), .busy(bz8)
    );
    wide_add_sequencer #(.WIDTH(32), .SLICE(32)) u_d32 (
        .clk(clk), .rst(rst), .req_valid(v32), .req_ready(rdy32),
        .req_a0(a0), .req_b0(b0), .req_a1(a1), .req_b1(b1), .req_cin(cin),
        .resp_valid(rv32), .resp_ready(rr), .resp_sum(s32), .resp_cout(c32),
        .resp_id(id32), .busy(bz32)
    );
    wide_add_sequencer #(.WIDTH(32), .SLICE(4)) u_d4 (
        .clk(clk), .rst(rst), .req_valid(v4), .req_ready(rdy4),
        .req_a0(a0), .req_b0(b0), .req_a1(a1), .req_b1(b1), .req_cin(cin),
        .resp_valid(rv4), .resp_ready(rr), .resp_sum(s4), .resp_cout(c4),
        .resp_id(id4), .busy(bz4)
    );

    assign m_ready  = cur == 0 ? rdy8 : cur == 1 ? rdy32 : rdy4;
    assign m_rvalid = cur == 0 ? rv8  : cur == 1 ? rv32  : rv4;
    assign m_sum    = cur == 0 ? s8   : cur == 1 ? s32   : s4;
    assign m_cout   = cur == 0 ? c8   : cur == 1 ? c32   : c4;
    assign m_id     = cur == 0 ? id8  : cur == 1 ? id32  : id4;
    assign m_busy   = cur == 0 ? bz8  : cur == 1 ? bz32  : bz4;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic set_v(input int sel, input logic [1:0] v);
        if (sel == 0) v8 = v;
        else if (sel == 1) v32 = v;
        else v4 = v;
    endtask

    function automatic logic [31:0] rnd();
        case ($urandom_range(0, 3))
            0: return 32'h0;
            1: return 32'hFFFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    // One request on port p of DUT sel; optionally stall the response for hold cycles.
    task automatic run_op(input int sel, input int p, input logic [31:0] a, input logic [31:0] b,
                          input logic ci, input int hold);
        int          n, k, lat;
        logic [32:0] e;
        lat = sel == 0 ? 4 : sel == 1 ? 1 : 8;
        e   = {1'b0, a} + {1'b0, b} + {32'b0, ci};
        cur = sel;
        rr  = hold == 0;
        if (p == 1) begin a1 = a; b1 = b; end
        else begin a0 = a; b0 = b; end
        cin[p] = ci;
        set_v(sel, 2'b01 << p);
        #1;
        n = 0;
        while (m_ready != (2'b01 << p) && n < 40) begin step(); n++; end
        chk("grant", m_ready, 2'b01 << p);
        step();
        set_v(sel, 2'b00);
        k = 0;
        while (!m_rvalid && k < 40) begin step(); k++; end
        chk("latency", k, lat);
        chk("sum", m_sum, e[31:0]);
        chk("cout", m_cout, e[32]);
        chk("id", m_id, p);
        for (int h = 0; h < hold; h++) begin
            set_v(sel, 2'b11);
            step();
            chk("hold_valid", m_rvalid, 1);
            chk("hold_sum", m_sum, e[31:0]);
            chk("hold_id", m_id, p);
            chk("hold_ready", m_ready, 2'b00);
        end
        set_v(sel, 2'b00);
        rr = 1'b1;
        step();
        chk("released", m_rvalid, 0);
        chk("idle_busy", m_busy, 0);
    endtask

    initial begin
        logic        seen, acc, g;
        int          last, nacc;
        logic [33:0] e;
        cur = 0; rr = 1'b1; cin = 2'b00;
        a0 = '0; b0 = '0; a1 = '0; b1 = '0;
        rst = 1'b1; v8 = 2'b11; v32 = 2'b11; v4 = 2'b11;
        #1;
        chk("rst_ready", rdy8, 2'b00);
        chk("rst_valid", rv8, 0);
        chk("rst_sum", s8, 0);
        chk("rst_busy", bz8, 0);
        step(); step();
        rst = 1'b0; v8 = 2'b00; v32 = 2'b00; v4 = 2'b00;
        step();

        run_op(0, 0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 0);
        run_op(0, 1, 32'h7FFF_FFFF, 32'h0000_0000, 1'b1, 0);

        // Contention: prio is 0 after the last accept (port 1), so grants run 0,1,0,1,0.
        cur = 0; rr = 1'b1;
        a0 = rnd(); b0 = rnd(); a1 = rnd(); b1 = rnd(); cin = 2'($urandom_range(0, 3));
        v8 = 2'b11;
        #1;
        last = 0; nacc = 0;
        for (int c = 0; c < 30; c++) begin
            chk("onehot", $countones(rdy8) <= 1, 1);
            if (rv8) begin
                chk("q_nonempty", q.size() > 0, 1);
                if (q.size() > 0) begin
                    e = q.pop_front();
                    chk("ct_sum", {c8, s8}, e[32:0]);
                    chk("ct_id", id8, e[33]);
                end
            end
            acc = |rdy8;
            g   = rdy8[1];
            if (acc) begin
                chk("alternate", g, nacc % 2);
                if (nacc > 0) chk("gap", c - last, 6);
                last = c;
                q.push_back({g, g ? ({1'b0, a1} + {1'b0, b1} + {32'b0, cin[1]})
                                  : ({1'b0, a0} + {1'b0, b0} + {32'b0, cin[0]})});
                nacc++;
            end
            @(posedge clk);
            #1;
            if (acc) begin
                if (g) begin a1 = rnd(); b1 = rnd(); end
                else begin a0 = rnd(); b0 = rnd(); end
                cin[g] = 1'($urandom_range(0, 1));
            end
            step();
        end
        v8 = 2'b00;
        chk("accepts", nacc, 5);
        chk("drained", q.size(), 0);
        step();

        run_op(0, 1, 32'hDEAD_BEEF, 32'h1234_5678, 1'b1, 5);

        // Reset during the second RUN cycle discards the operation.
        cur = 0;
        a1 = 32'h1234_5678; b1 = 32'h1111_1111; cin[1] = 1'b1; v8 = 2'b10;
        #1;
        chk("mid_grant", rdy8, 2'b10);
        step();
        v8 = 2'b00;
        step();
        rst = 1'b1; v8 = 2'b11;
        #1;
        chk("mid_ready", rdy8, 2'b00);
        chk("mid_valid", rv8, 0);
        chk("mid_busy", bz8, 0);
        chk("mid_sum", s8, 0);
        chk("mid_id", id8, 0);
        chk("mid_cout", c8, 0);
        step();
        rst = 1'b0; v8 = 2'b00;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin step(); seen |= rv8; end
        chk("no_resp", seen, 0);
        run_op(0, 0, 32'h89AB_CDEF, 32'h7654_3210, 1'b1, 0);

        for (int s = 0; s < 3; s++) begin
            for (int i = 0; i < (s == 0 ? 200 : 1000); i++) begin
                run_op(s, int'($urandom_range(0, 1)), rnd(), rnd(), 1'($urandom_range(0, 1)),
                       $urandom_range(0, 9) == 0 ? int'($urandom_range(1, 3)) : 0);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
